// File: rtl/mgia_vram_slave_pkg.sv
// ----------------------------------------------------------------------------
// mgia_vram_slave_pkg
// Shared definitions for the MGIA video RAM slave: FSM state encoding,
// default SRAM wait-state count, word-address width and the width of the
// access timer counter.
// ----------------------------------------------------------------------------
package mgia_vram_slave_pkg;

    localparam int MGIA_ADR_W           = 13;  // word address bits [13:1]
    localparam int MGIA_WAIT_STATES_DEF = 2;   // extra clocks per SRAM access
    localparam int MGIA_CNT_W           = 3;   // holds 0..7 wait states

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_M_RD  = 3'd1,
        ST_C_RD  = 3'd2,
        ST_C_WR  = 3'd3,
        ST_M_ACK = 3'd4,
        ST_C_ACK = 3'd5
    } mgia_state_e;

endpackage

// File: rtl/sram_access_timer.sv
// ----------------------------------------------------------------------------
// sram_access_timer
// Down-counter that times one SRAM access. Loaded with the wait-state count
// when an access starts, decremented on every access clock; done_o flags
// the last clock of the access (terminal count of zero).
//
// Ports
//   clk_i       clock
//   rst_i       asynchronous active-high reset (counter -> 0)
//   load_i      load load_val_i into the counter
//   load_val_i  wait-state count for the coming access
//   count_i     decrement while the access is in progress
//   done_o      counter at terminal count: current clock is the last one
// ----------------------------------------------------------------------------
module sram_access_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             count_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mgia_vram_slave.sv
// ----------------------------------------------------------------------------
// mgia_vram_slave
// Shares one asynchronous 16-bit SRAM between a read-only video fetch port
// (MGIA) and a read/write CPU port. Contention is resolved round-robin:
// the port that was not granted last wins.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no access; arbitrate pending requests
//   M_RD   | video read in progress (OE high, BE=11)
//   C_RD   | CPU read in progress (OE high, BE=11)
//   C_WR   | CPU write in progress (WE high, data driven, BE=SEL)
//   M_ACK  | one-clock MGIA_ACK_O
//   C_ACK  | one-clock CPU_ACK_O
//
// Ports
//   CLK_I_25MHZ, RST_I                 clock, async active-high reset
//   MGIA_ADR_I/CYC_I/STB_I             video read request
//   MGIA_DAT_O/ACK_O                   video read data and acknowledge
//   CPU_ADR_I/DAT_I/SEL_I/WE_I/CYC_I/STB_I  CPU request
//   CPU_DAT_O/ACK_O                    CPU read data and acknowledge
//   SRAM_ADR_O/DAT_O/DAT_I             SRAM address and data buses
//   SRAM_OE_O/WE_O/BE_O/DOE_O          SRAM strobes, data driver enable
// ----------------------------------------------------------------------------
module mgia_vram_slave
    import mgia_vram_slave_pkg::*;
#(
    parameter int WAIT_STATES = MGIA_WAIT_STATES_DEF
) (
    input  logic                   CLK_I_25MHZ,
    input  logic                   RST_I,
    input  logic [MGIA_ADR_W:1]    MGIA_ADR_I,
    input  logic                   MGIA_CYC_I,
    input  logic                   MGIA_STB_I,
    output logic [15:0]            MGIA_DAT_O,
    output logic                   MGIA_ACK_O,
    input  logic [MGIA_ADR_W:1]    CPU_ADR_I,
    input  logic [15:0]            CPU_DAT_I,
    input  logic [1:0]             CPU_SEL_I,
    input  logic                   CPU_WE_I,
    input  logic                   CPU_CYC_I,
    input  logic                   CPU_STB_I,
    output logic [15:0]            CPU_DAT_O,
    output logic                   CPU_ACK_O,
    output logic [MGIA_ADR_W:1]    SRAM_ADR_O,
    output logic [15:0]            SRAM_DAT_O,
    input  logic [15:0]            SRAM_DAT_I,
    output logic                   SRAM_OE_O,
    output logic                   SRAM_WE_O,
    output logic [1:0]             SRAM_BE_O,
    output logic                   SRAM_DOE_O
);

    localparam logic [MGIA_CNT_W-1:0] WS_LOAD = MGIA_CNT_W'(WAIT_STATES);

    mgia_state_e             state_q, state_d;
    logic                    last_cpu_q, last_cpu_d;
    logic [MGIA_ADR_W:1]     adr_q, adr_d;
    logic [15:0]             wdat_q, wdat_d;
    logic [1:0]              sel_q, sel_d;
    logic                    we_q, we_d;
    logic                    abort_q, abort_d;
    logic [15:0]             mgia_dat_q, mgia_dat_d;
    logic [15:0]             cpu_dat_q, cpu_dat_d;

    logic                    m_req;
    logic                    c_req;
    logic                    tmr_load;
    logic                    tmr_count;
    logic                    tmr_done;

    assign m_req = MGIA_CYC_I & MGIA_STB_I;
    assign c_req = CPU_CYC_I & CPU_STB_I;

    sram_access_timer #(
        .CNT_W (MGIA_CNT_W)
    ) u_timer (
        .clk_i      (CLK_I_25MHZ),
        .rst_i      (RST_I),
        .load_i     (tmr_load),
        .load_val_i (WS_LOAD),
        .count_i    (tmr_count),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        last_cpu_d = last_cpu_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        abort_d    = abort_q;
        mgia_dat_d = mgia_dat_q;
        cpu_dat_d  = cpu_dat_q;
        tmr_load   = 1'b0;
        tmr_count  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // MGIA wins when alone, or on contention if the CPU had the last grant
                if (m_req && (!c_req || last_cpu_q)) begin
                    state_d    = ST_M_RD;
                    last_cpu_d = 1'b0;
                    adr_d      = MGIA_ADR_I;
                    sel_d      = 2'b11;
                    we_d       = 1'b0;
                    abort_d    = 1'b0;
                    tmr_load   = 1'b1;
                end else if (c_req) begin
                    state_d    = CPU_WE_I ? ST_C_WR : ST_C_RD;
                    last_cpu_d = 1'b1;
                    adr_d      = CPU_ADR_I;
                    wdat_d     = CPU_DAT_I;
                    sel_d      = CPU_SEL_I;
                    we_d       = CPU_WE_I;
                    abort_d    = 1'b0;
                    tmr_load   = 1'b1;
                end
            end

            ST_M_RD: begin
                tmr_count = 1'b1;
                if (!MGIA_CYC_I) begin
                    abort_d = 1'b1;
                end
                if (tmr_done) begin
                    mgia_dat_d = SRAM_DAT_I;
                    // an abandoned cycle still finishes on the SRAM but is not acknowledged
                    state_d    = (abort_q || !MGIA_CYC_I) ? ST_IDLE : ST_M_ACK;
                end
            end

            ST_C_RD: begin
                tmr_count = 1'b1;
                if (!CPU_CYC_I) begin
                    abort_d = 1'b1;
                end
                if (tmr_done) begin
                    cpu_dat_d = SRAM_DAT_I;
                    state_d   = (abort_q || !CPU_CYC_I) ? ST_IDLE : ST_C_ACK;
                end
            end

            ST_C_WR: begin
                tmr_count = 1'b1;
                if (!CPU_CYC_I) begin
                    abort_d = 1'b1;
                end
                if (tmr_done) begin
                    state_d = (abort_q || !CPU_CYC_I) ? ST_IDLE : ST_C_ACK;
                end
            end

            ST_M_ACK: state_d = ST_IDLE;
            ST_C_ACK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I_25MHZ or posedge RST_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            last_cpu_q <= 1'b1;
            adr_q      <= '0;
            wdat_q     <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            abort_q    <= 1'b0;
            mgia_dat_q <= '0;
            cpu_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_cpu_q <= last_cpu_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            abort_q    <= abort_d;
            mgia_dat_q <= mgia_dat_d;
            cpu_dat_q  <= cpu_dat_d;
        end
    end

    // Strobes decode straight from the state register so an async reset
    // drops them in the same clock it is asserted.
    always_comb begin
        SRAM_OE_O  = 1'b0;
        SRAM_WE_O  = 1'b0;
        SRAM_DOE_O = 1'b0;
        SRAM_BE_O  = 2'b00;
        case (state_q)
            ST_M_RD, ST_C_RD: begin
                SRAM_OE_O = 1'b1;
                SRAM_BE_O = 2'b11;
            end
            ST_C_WR: begin
                // SEL=00 is a legal no-op write: no WE pulse, still acknowledged
                SRAM_WE_O  = we_q & (|sel_q);
                SRAM_DOE_O = 1'b1;
                SRAM_BE_O  = sel_q;
            end
            default: ;
        endcase
    end

    assign SRAM_ADR_O = adr_q;
    assign SRAM_DAT_O = wdat_q;
    assign MGIA_ACK_O = (state_q == ST_M_ACK);
    assign CPU_ACK_O  = (state_q == ST_C_ACK);
    assign MGIA_DAT_O = mgia_dat_q;
    assign CPU_DAT_O  = cpu_dat_q;

endmodule

// File: tb/tb_mgia_vram_slave.sv
module tb_mgia_vram_slave;

    localparam int WS = 2;

    logic        clk;
    logic        rst;
    logic [13:1] m_adr;
    logic        m_cyc, m_stb;
    logic [15:0] m_dat;
    logic        m_ack;
    logic [13:1] c_adr;
    logic [15:0] c_wdat;
    logic [1:0]  c_sel;
    logic        c_we, c_cyc, c_stb;
    logic [15:0] c_dat;
    logic        c_ack;
    logic [13:1] s_adr;
    logic [15:0] s_dout;
    logic [15:0] s_din;
    logic        s_oe, s_we, s_doe;
    logic [1:0]  s_be;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:8191];

    mgia_vram_slave #(.WAIT_STATES(WS)) dut (
        .CLK_I_25MHZ (clk),
        .RST_I       (rst),
        .MGIA_ADR_I  (m_adr),
        .MGIA_CYC_I  (m_cyc),
        .MGIA_STB_I  (m_stb),
        .MGIA_DAT_O  (m_dat),
        .MGIA_ACK_O  (m_ack),
        .CPU_ADR_I   (c_adr),
        .CPU_DAT_I   (c_wdat),
        .CPU_SEL_I   (c_sel),
        .CPU_WE_I    (c_we),
        .CPU_CYC_I   (c_cyc),
        .CPU_STB_I   (c_stb),
        .CPU_DAT_O   (c_dat),
        .CPU_ACK_O   (c_ack),
        .SRAM_ADR_O  (s_adr),
        .SRAM_DAT_O  (s_dout),
        .SRAM_DAT_I  (s_din),
        .SRAM_OE_O   (s_oe),
        .SRAM_WE_O   (s_we),
        .SRAM_BE_O   (s_be),
        .SRAM_DOE_O  (s_doe)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // async SRAM model
    assign s_din = mem[s_adr];
    always @(posedge clk) begin
        if (s_we && s_doe) begin
            if (s_be[0]) mem[s_adr][7:0]  <= s_dout[7:0];
            if (s_be[1]) mem[s_adr][15:8] <= s_dout[15:8];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // every-clock invariants: OE/WE exclusive, DOE only with write strobes, ACK width 1
    logic m_ack_prev = 1'b0;
    logic c_ack_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            check_val("oe_we_excl", 32'(s_oe & s_we), 32'd0);
            check_val("m_ack_width", 32'(m_ack & m_ack_prev), 32'd0);
            check_val("c_ack_width", 32'(c_ack & c_ack_prev), 32'd0);
            check_val("doe_no_oe", 32'(s_doe & s_oe), 32'd0);
        end
        m_ack_prev <= m_ack & ~rst;
        c_ack_prev <= c_ack & ~rst;
    end

    task automatic mgia_read(input logic [13:1] a, output int lat, output logic [15:0] d);
        m_adr = a; m_cyc = 1'b1; m_stb = 1'b1;
        lat = -1; d = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (m_ack) begin
                lat = i; d = m_dat;
                break;
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [13:1] a, input logic [15:0] wd,
                              input logic [1:0] sel, output int lat, output logic [15:0] rd,
                              output int we_cyc, output logic [1:0] be_seen, output logic adr_ok);
        c_adr = a; c_wdat = wd; c_sel = sel; c_we = we; c_cyc = 1'b1; c_stb = 1'b1;
        lat = -1; rd = '0; we_cyc = 0; be_seen = 2'b00; adr_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (s_we) begin
                we_cyc++;
                be_seen = s_be;
                if (s_adr != a) adr_ok = 1'b0;
            end
            if (c_ack) begin
                lat = i; rd = c_dat;
                break;
            end
        end
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0;
    endtask

    task automatic contention(input logic [13:1] ma, input logic [13:1] ca,
                              output int m_t, output int c_t,
                              output logic [15:0] md, output logic [15:0] cd);
        m_adr = ma; m_cyc = 1'b1; m_stb = 1'b1;
        c_adr = ca; c_we = 1'b0; c_sel = 2'b11; c_cyc = 1'b1; c_stb = 1'b1;
        m_t = -1; c_t = -1; md = '0; cd = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (m_ack && m_t < 0) begin
                m_t = i; md = m_dat; m_cyc = 1'b0; m_stb = 1'b0;
            end
            if (c_ack && c_t < 0) begin
                c_t = i; cd = c_dat; c_cyc = 1'b0; c_stb = 1'b0;
            end
            if (m_t >= 0 && c_t >= 0) break;
        end
        m_cyc = 1'b0; m_stb = 1'b0; c_cyc = 1'b0; c_stb = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, we_cyc, m_t, c_t, m_acks;
        logic [15:0] d, md, cd;
        logic [1:0]  be_seen;
        logic        adr_ok;

        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[13'h0040] = 16'hA5C3;
        mem[13'h0080] = 16'h5A5A;
        mem[13'h0100] = 16'hBEEF;

        rst = 1'b1;
        m_adr = '0; m_cyc = 1'b0; m_stb = 1'b0;
        c_adr = '0; c_wdat = '0; c_sel = 2'b00; c_we = 1'b0; c_cyc = 1'b0; c_stb = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        check_val("rst_strobes", {28'd0, s_oe, s_we, s_doe, 1'b0}, 32'd0);
        check_val("rst_be", 32'(s_be), 32'd0);
        check_val("rst_adr", 32'(s_adr), 32'd0);
        check_val("rst_acks", {30'd0, m_ack, c_ack}, 32'd0);
        check_val("rst_dat", {m_dat, c_dat}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic MGIA read: ACK on clock WS+2
        mgia_read(13'h0040, lat, d);
        check_val("m_rd_lat", 32'(lat), 32'd4);
        check_val("m_rd_dat", 32'(d), 32'hA5C3);
        @(negedge clk);
        check_val("m_ack_drop", 32'(m_ack), 32'd0);
        check_val("m_dat_hold", 32'(m_dat), 32'hA5C3);

        // CPU upper-byte write then read-back
        cpu_access(1'b1, 13'h0100, 16'h1234, 2'b10, lat, d, we_cyc, be_seen, adr_ok);
        check_val("c_wr_lat", 32'(lat), 32'd4);
        check_val("c_wr_we_cycles", 32'(we_cyc), 32'd3);
        check_val("c_wr_be", 32'(be_seen), 32'h2);
        check_val("c_wr_adr", 32'(adr_ok), 32'd1);
        @(negedge clk);
        cpu_access(1'b0, 13'h0100, 16'h0000, 2'b11, lat, d, we_cyc, be_seen, adr_ok);
        check_val("c_rd_lat", 32'(lat), 32'd4);
        check_val("c_rd_back", 32'(d), 32'h12EF);

        // SEL=00 write: acknowledged, memory untouched
        @(negedge clk);
        cpu_access(1'b1, 13'h0100, 16'h0000, 2'b00, lat, d, we_cyc, be_seen, adr_ok);
        check_val("c_sel0_lat", 32'(lat), 32'd4);
        check_val("c_sel0_we", 32'(we_cyc), 32'd0);
        @(negedge clk);
        cpu_access(1'b0, 13'h0100, 16'h0000, 2'b11, lat, d, we_cyc, be_seen, adr_ok);
        check_val("c_sel0_back", 32'(d), 32'h12EF);

        // contention, CPU granted last -> MGIA first
        @(negedge clk);
        contention(13'h0040, 13'h0080, m_t, c_t, md, cd);
        check_val("arbA_m_t", 32'(m_t), 32'd4);
        check_val("arbA_c_t", 32'(c_t), 32'd9);
        check_val("arbA_m_dat", 32'(md), 32'hA5C3);
        check_val("arbA_c_dat", 32'(cd), 32'h5A5A);

        // MGIA alone, then contention -> CPU first
        @(negedge clk);
        mgia_read(13'h0080, lat, d);
        check_val("m_rd2_dat", 32'(d), 32'h5A5A);
        @(negedge clk);
        contention(13'h0040, 13'h0100, m_t, c_t, md, cd);
        check_val("arbB_c_t", 32'(c_t), 32'd4);
        check_val("arbB_m_t", 32'(m_t), 32'd9);
        check_val("arbB_c_dat", 32'(cd), 32'h12EF);
        check_val("arbB_m_dat", 32'(md), 32'hA5C3);

        // CPU alone so the CPU holds the last grant
        @(negedge clk);
        cpu_access(1'b0, 13'h0040, 16'h0000, 2'b11, lat, d, we_cyc, be_seen, adr_ok);
        check_val("c_rd2_dat", 32'(d), 32'hA5C3);

        // MGIA abandons its cycle one clock after grant; pending CPU served after
        @(negedge clk);
        m_adr = 13'h0040; m_cyc = 1'b1; m_stb = 1'b1;
        c_adr = 13'h0080; c_we = 1'b0; c_sel = 2'b11; c_cyc = 1'b1; c_stb = 1'b1;
        m_acks = 0; c_t = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (m_ack) m_acks++;
            if (i == 1) begin
                check_val("abort_granted_oe", 32'(s_oe), 32'd1);
                m_cyc = 1'b0; m_stb = 1'b0;
            end
            if (i == 4) check_val("abort_idle_oe", 32'(s_oe), 32'd0);
            if (c_ack && c_t < 0) begin
                c_t = i; cd = c_dat; c_cyc = 1'b0; c_stb = 1'b0;
            end
        end
        c_cyc = 1'b0; c_stb = 1'b0;
        check_val("abort_no_m_ack", 32'(m_acks), 32'd0);
        check_val("abort_c_t", 32'(c_t), 32'd8);
        check_val("abort_c_dat", 32'(cd), 32'h5A5A);

        // reset in the middle of a CPU write
        @(negedge clk);
        c_adr = 13'h0200; c_wdat = 16'hFFFF; c_sel = 2'b11; c_we = 1'b1; c_cyc = 1'b1; c_stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("midwr_we_before", {30'd0, s_we, s_doe}, 32'h3);
        rst = 1'b1;
        #1;
        check_val("midwr_strobes", {28'd0, s_oe, s_we, s_doe, c_ack}, 32'd0);
        check_val("midwr_be_adr", {16'd0, 1'b0, s_adr, s_be}, 32'd0);
        check_val("midwr_dat", {m_dat, c_dat}, 32'd0);
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (c_ack) m_acks++;
        end
        check_val("midwr_no_c_ack", 32'(m_acks), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
